operand_entry: RTL

OPERAND_ENTRY -- requirements
Module: operand_entry

---
 rtl/operand_entry_pkg.sv | 24 ++
 rtl/operand_entry_conv.sv | 69 ++++++
 rtl/operand_entry.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/operand_entry_pkg.sv
// Shared types for the operand entry block: event kinds, controller states
// and the BCD digit type.
package operand_entry_pkg;

    typedef enum logic [1:0] {
        EV_DIGIT = 2'd0,
        EV_BSP   = 2'd1,
        EV_CLEAR = 2'd2,
        EV_RSVD  = 2'd3
    } ev_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    function automatic logic is_bcd(input bcd_digit_t d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/operand_entry_conv.sv
// Iterative BCD-to-binary converter: one decimal digit per clock, most
// significant first; done pulses in the cycle the result is valid.
module bcd_to_bin_seq
    import operand_entry_pkg::*;
#(
    parameter int NDIGITS = 4,
    parameter int BIN_W   = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NDIGITS-1:0]   bcd,
    output logic [BIN_W-1:0]       bin,
    output logic                   done
);
    localparam int BCD_W = 4 * NDIGITS;

    logic [BCD_W-1:0] sh_q;
    logic [BIN_W-1:0] acc_q;
    logic [3:0]       rem_q;
    logic             busy_q;
    logic             done_q;
    bcd_digit_t       top_start;
    bcd_digit_t       top_sh;

    assign top_start = bcd[BCD_W-1 -: 4];
    assign top_sh    = sh_q[BCD_W-1 -: 4];

    // Result wraps modulo 2^BIN_W when the operand is wider than BIN_W allows.
    function automatic logic [BIN_W-1:0] mac10(input logic [BIN_W-1:0] a,
                                               input bcd_digit_t d);
        logic [BIN_W+3:0] t;
        t = {4'b0000, a} * (BIN_W+4)'(10) + (BIN_W+4)'(d);
        return t[BIN_W-1:0];
    endfunction

    // The first digit is folded in at start, so NDIGITS-1 further steps remain.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rem_q  <= 4'd0;
        end else if (start) begin
            busy_q <= (NDIGITS > 1);
            done_q <= (NDIGITS == 1);
            rem_q  <= 4'(NDIGITS - 1);
        end else if (busy_q) begin
            rem_q  <= rem_q - 4'd1;
            busy_q <= (rem_q != 4'd1);
            done_q <= (rem_q == 4'd1);
        end else begin
            done_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            acc_q <= mac10('0, top_start);
            sh_q  <= bcd << 4;
        end else if (busy_q) begin
            acc_q <= mac10(acc_q, top_sh);
            sh_q  <= sh_q << 4;
        end
    end

    assign bin  = acc_q;
    assign done = done_q;

endmodule

// File: rtl/operand_entry.sv
// Keypad-style decimal operand entry: per-operand BCD digit buffers with a
// shared sequential converter that refreshes the binary value after edits.
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int NUM_OPS = 2,
    parameter int NDIGITS = 4,
    parameter int BIN_W   = 14,
    localparam int SEL_W  = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ev_valid,
    input  logic [1:0]                    ev_kind,
    input  logic [3:0]                    digit,
    input  logic [SEL_W-1:0]              op_sel,
    output logic                          ready,
    output logic [NUM_OPS*4*NDIGITS-1:0]  op_bcd,
    output logic [NUM_OPS*BIN_W-1:0]      op_bin,
    output logic [NUM_OPS*4-1:0]          op_count,
    output logic [NUM_OPS-1:0]            full,
    output logic                          upd_valid,
    output logic [SEL_W-1:0]              upd_op,
    output logic                          err
);
    localparam int BCD_W = 4 * NDIGITS;

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   bcd_q [NUM_OPS];
    logic [BIN_W-1:0]   bin_q [NUM_OPS];
    logic [3:0]         cnt_q [NUM_OPS];
    logic [NUM_OPS-1:0] full_q;
    logic [SEL_W-1:0]   lat_op_q, upd_op_q;
    logic               upd_q, err_q;

    ev_kind_t           kind;
    logic               sel_ok, accept, bad;
    logic               is_digit, is_bsp, is_clr;
    logic               overflow, underflow, lead_zero;
    logic               do_conv, do_imm, do_err, finish;
    logic [BCD_W-1:0]   cur_bcd, new_bcd;
    logic [3:0]         cur_cnt, new_cnt;
    logic [BIN_W-1:0]   conv_bin;
    logic               conv_done;

    assign ready  = (state_q == ST_IDLE);
    assign finish = (state_q == ST_CONV) && conv_done;

    always_comb begin
        kind    = ev_kind_t'(ev_kind);
        sel_ok  = 1'b0;
        cur_bcd = '0;
        cur_cnt = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (op_sel == SEL_W'(k)) begin
                sel_ok  = 1'b1;
                cur_bcd = bcd_q[k];
                cur_cnt = cnt_q[k];
            end
        end
        accept    = ev_valid && (state_q == ST_IDLE);
        bad       = !sel_ok || (kind == EV_RSVD) || ((kind == EV_DIGIT) && !is_bcd(digit));
        is_digit  = accept && !bad && (kind == EV_DIGIT);
        is_bsp    = accept && !bad && (kind == EV_BSP);
        is_clr    = accept && !bad && (kind == EV_CLEAR);
        overflow  = is_digit && (cur_cnt == 4'(NDIGITS));
        underflow = is_bsp && (cur_cnt == 4'd0);
        lead_zero = is_digit && !overflow && (cur_cnt == 4'd0) && (digit == 4'd0);
        do_err    = (accept && bad) || overflow || underflow;
        do_conv   = (is_digit && !overflow && !lead_zero) || (is_bsp && !underflow);
        do_imm    = lead_zero || is_clr;
        new_bcd   = is_digit ? ((cur_bcd << 4) | BCD_W'(digit)) : (cur_bcd >> 4);
        new_cnt   = is_digit ? (cur_cnt + 4'd1) : (cur_cnt - 4'd1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (do_conv) state_d = ST_CONV;
            ST_CONV: if (conv_done) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            upd_q    <= 1'b0;
            err_q    <= 1'b0;
            upd_op_q <= '0;
            lat_op_q <= '0;
        end else begin
            state_q <= state_d;
            upd_q   <= finish || do_imm;
            err_q   <= do_err;
            if (do_conv)
                lat_op_q <= op_sel;
            if (finish)
                upd_op_q <= lat_op_q;
            else if (do_imm)
                upd_op_q <= op_sel;
        end
    end

    // Digit buffers change at accept; the binary copy only once conversion ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_OPS; k++) begin
                bcd_q[k] <= '0;
                bin_q[k] <= '0;
                cnt_q[k] <= '0;
            end
            full_q <= '0;
        end else begin
            for (int k = 0; k < NUM_OPS; k++) begin
                if (op_sel == SEL_W'(k)) begin
                    if (do_conv) begin
                        bcd_q[k] <= new_bcd;
                        cnt_q[k] <= new_cnt;
                        if (is_bsp)
                            full_q[k] <= 1'b0;
                    end
                    if (overflow)
                        full_q[k] <= 1'b1;
                    if (is_clr) begin
                        bcd_q[k]  <= '0;
                        bin_q[k]  <= '0;
                        cnt_q[k]  <= '0;
                        full_q[k] <= 1'b0;
                    end
                end
                if (finish && (lat_op_q == SEL_W'(k)))
                    bin_q[k] <= conv_bin;
            end
        end
    end

    bcd_to_bin_seq #(
        .NDIGITS (NDIGITS),
        .BIN_W   (BIN_W)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (do_conv),
        .bcd   (new_bcd),
        .bin   (conv_bin),
        .done  (conv_done)
    );

    always_comb begin
        op_bcd   = '0;
        op_bin   = '0;
        op_count = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            op_bcd[k*BCD_W +: BCD_W]   = bcd_q[k];
            op_bin[k*BIN_W +: BIN_W]   = bin_q[k];
            op_count[k*4 +: 4]         = cnt_q[k];
        end
    end

    assign full      = full_q;
    assign upd_valid = upd_q;
    assign upd_op    = upd_op_q;
    assign err       = err_q;

endmodule
